// File: rtl/mem_responder_if.sv
// Strobe-based single-word memory bus between a requester (master) and mem_responder (slave).
interface mem_responder_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 26
);
    logic                  READ;
    logic                  WRITE;
    logic [ADDR_WIDTH-1:0] ADDR;
    logic [DATA_WIDTH-1:0] DATA_IN;
    logic [DATA_WIDTH-1:0] DATA_OUT;
    logic                  DATA_OE;
    logic                  READY;
    logic                  ERR;

    modport master (
        output READ, WRITE, ADDR, DATA_IN,
        input  DATA_OUT, DATA_OE, READY, ERR
    );

    modport slave (
        input  READ, WRITE, ADDR, DATA_IN,
        output DATA_OUT, DATA_OE, READY, ERR
    );
endinterface

// File: rtl/mem_responder.sv
// Slow-memory responder: captures a READ/WRITE strobe, waits WAIT_CYCLES, completes with a READY pulse.
// Optional MEM_RESPONDER_STATS_EN adds saturating RD_CNT/WR_CNT completion counters.
module mem_responder #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 26,
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        RST,
`ifdef MEM_RESPONDER_STATS_EN
    output logic [15:0] RD_CNT,
    output logic [15:0] WR_CNT,
`endif
    mem_responder_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    logic [1:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  op_wr_q, op_wr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  both_q, both_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  oe_q, oe_d;
    logic                  ready_q, ready_d;
    logic                  err_q, err_d;

    logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];

    logic                  in_range;
    logic [DEPTH_LOG2-1:0] idx;
    logic                  strobe_held;

    assign in_range    = (addr_q >> DEPTH_LOG2) == '0;
    assign idx         = addr_q[DEPTH_LOG2-1:0];
    assign strobe_held = op_wr_q ? bus.WRITE : bus.READ;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_wr_d = op_wr_q;
        addr_d  = addr_q;
        data_d  = data_q;
        both_d  = 1'b0;
        dout_d  = '0;
        oe_d    = 1'b0;
        ready_d = 1'b0;
        // conflicting strobes report one cycle after they were seen
        err_d   = both_q;
        case (state_q)
            S_IDLE: begin
                if (bus.READ && bus.WRITE) begin
                    both_d  = 1'b1;
                    state_d = S_HOLD;
                end else if (bus.READ || bus.WRITE) begin
                    op_wr_d = bus.WRITE;
                    addr_d  = bus.ADDR;
                    data_d  = bus.DATA_IN;
                    cnt_d   = WAIT_INIT;
                    state_d = (WAIT_CYCLES == 0) ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (!strobe_held)
                    state_d = S_IDLE;
                else if (cnt_q <= 4'd1)
                    state_d = S_DONE;
            end
            S_DONE: begin
                ready_d = 1'b1;
                err_d   = ~in_range;
                oe_d    = ~op_wr_q;
                if (!op_wr_q && in_range)
                    dout_d = mem[idx];
                state_d = S_HOLD;
            end
            S_HOLD: begin
                // wait for both strobes low so a held strobe cannot re-trigger
                if (!bus.READ && !bus.WRITE)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_wr_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            both_q  <= 1'b0;
            dout_q  <= '0;
            oe_q    <= 1'b0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_wr_q <= op_wr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            both_q  <= both_d;
            dout_q  <= dout_d;
            oe_q    <= oe_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    // storage survives reset; a reset edge suppresses the pending commit
    always_ff @(posedge CLK) begin
        if (RST && state_q == S_DONE && op_wr_q && in_range)
            mem[idx] <= data_q;
    end

    assign bus.DATA_OUT = dout_q;
    assign bus.DATA_OE  = oe_q;
    assign bus.READY    = ready_q;
    assign bus.ERR      = err_q;

`ifdef MEM_RESPONDER_STATS_EN
    logic [15:0] rd_cnt_q, wr_cnt_q;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else if (state_q == S_DONE && in_range) begin
            if (op_wr_q) begin
                if (wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
            end else begin
                if (rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
            end
        end
    end

    assign RD_CNT = rd_cnt_q;
    assign WR_CNT = wr_cnt_q;
`else
    // statistics counters not built
`endif
endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench: two responders (2 and 0 wait states) share a transaction-level reference model.
`timescale 1ns/1ps
module tb_mem_responder;
  localparam int DW = 32;
  localparam int AW = 26;
  localparam int DL = 10;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  logic          rd = 1'b0, wr = 1'b0, sel = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] din  = '0;

  mem_responder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus2 ();
  mem_responder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus0 ();

  assign bus2.READ    = rd & ~sel;
  assign bus2.WRITE   = wr & ~sel;
  assign bus2.ADDR    = addr;
  assign bus2.DATA_IN = din;
  assign bus0.READ    = rd & sel;
  assign bus0.WRITE   = wr & sel;
  assign bus0.ADDR    = addr;
  assign bus0.DATA_IN = din;

`ifdef MEM_RESPONDER_STATS_EN
  logic [15:0] rdcnt2, wrcnt2, rdcnt0, wrcnt0;
`endif

  mem_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH_LOG2(DL), .WAIT_CYCLES(2)) dut2 (
    .CLK(CLK), .RST(RST),
`ifdef MEM_RESPONDER_STATS_EN
    .RD_CNT(rdcnt2), .WR_CNT(wrcnt2),
`endif
    .bus(bus2));

  mem_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH_LOG2(DL), .WAIT_CYCLES(0)) dut0 (
    .CLK(CLK), .RST(RST),
`ifdef MEM_RESPONDER_STATS_EN
    .RD_CNT(rdcnt0), .WR_CNT(wrcnt0),
`endif
    .bus(bus0));

  logic          o_ready, o_err, o_oe;
  logic [DW-1:0] o_dout;
  assign o_ready = sel ? bus0.READY    : bus2.READY;
  assign o_err   = sel ? bus0.ERR      : bus2.ERR;
  assign o_oe    = sel ? bus0.DATA_OE  : bus2.DATA_OE;
  assign o_dout  = sel ? bus0.DATA_OUT : bus2.DATA_OUT;

  int checks = 0;
  int errors = 0;

  // reference model, index 0 = 2-wait responder, 1 = 0-wait responder
  logic [DW-1:0] mdl [2][32];
  int            rdc [2];
  int            wrc [2];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int wcyc(input int s);
    return (s != 0) ? 0 : 2;
  endfunction

  // an access completes unless strobes conflict or the strobe falls while waiting
  function automatic bit completes(input bit r, input bit w, input int hold, input int s);
    return !(r && w) && !(wcyc(s) > 0 && hold <= wcyc(s));
  endfunction

  function automatic void predict(input bit r, input bit w, input logic [AW-1:0] a, input int hold,
                                  input int s, output int er, output int ee, output int eo,
                                  output logic [DW-1:0] erd);
    int  W;
    bit  inr;
    W   = wcyc(s);
    inr = (a < AW'(1 << DL));
    er = -1; ee = -1; eo = -1; erd = '0;
    if (r && w) ee = 1;
    else if (completes(r, w, hold, s)) begin
      er = W + 1;
      if (!inr) ee = W + 1;
      if (r) begin
        eo = W + 1;
        if (inr) erd = mdl[s][a[4:0]];
      end
    end
  endfunction

  function automatic void model_commit(input bit r, input bit w, input logic [AW-1:0] a,
                                       input logic [DW-1:0] d, input int hold, input int s);
    if (completes(r, w, hold, s) && a < AW'(1 << DL)) begin
      if (w) begin mdl[s][a[4:0]] = d; wrc[s]++; end
      else rdc[s]++;
    end
  endfunction

  // Drive one access starting at a negedge; sample after each posedge; drop strobes after 'hold' edges.
  task automatic do_txn(input bit r, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input int hold, input int er, input int ee, input int eo,
                        input logic [DW-1:0] erd, input string nm);
    int s, ready_at, err_at, oe_at, nready, nerr, bad;
    logic [DW-1:0] rdat;
    s = int'(sel);
    ready_at = -1; err_at = -1; oe_at = -1; nready = 0; nerr = 0; bad = 0; rdat = '0;
    rd = r; wr = w; addr = a; din = d;
    for (int j = 0; j < wcyc(s) + 6; j++) begin
      @(negedge CLK);
      if (o_ready) begin
        nready++;
        if (ready_at < 0) begin ready_at = j; rdat = o_dout; end
      end else if (o_oe || o_dout != '0) bad++;
      if (o_err) begin nerr++; if (err_at < 0) err_at = j; end
      if (o_oe && oe_at < 0) oe_at = j;
      if (j == 0) begin addr = AW'($urandom); din = $urandom; end
      if (j + 1 == hold) begin rd = 1'b0; wr = 1'b0; end
    end
    rd = 1'b0; wr = 1'b0;
    chk({nm, ".ready_at"}, ready_at, er);
    chk({nm, ".ready_cnt"}, nready, (er >= 0) ? 1 : 0);
    chk({nm, ".err_at"}, err_at, ee);
    chk({nm, ".err_cnt"}, nerr, (ee >= 0) ? 1 : 0);
    chk({nm, ".oe_at"}, oe_at, eo);
    chk({nm, ".rdata"}, rdat, erd);
    chk({nm, ".idle_out"}, bad, 0);
    model_commit(r, w, a, d, hold, s);
  endtask

  task automatic auto_txn(input bit r, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input int hold, input string nm);
    int er, ee, eo;
    logic [DW-1:0] erd;
    predict(r, w, a, hold, int'(sel), er, ee, eo, erd);
    do_txn(r, w, a, d, hold, er, ee, eo, erd, nm);
  endtask

  // Write addr 3 on the 2-wait responder, pull reset low after sample at_j, expect quiet outputs and no commit.
  task automatic rst_mid(input int at_j, input string nm);
    sel = 1'b0; rd = 1'b0; wr = 1'b1; addr = AW'(3); din = 32'h0000_0099;
    for (int j = 0; j <= at_j + 1; j++) begin
      @(negedge CLK);
      if (j == at_j) begin RST = 1'b0; wr = 1'b0; end
      else if (j == at_j + 1) begin
        chk({nm, ".ready"}, bus2.READY, 0);
        chk({nm, ".err"}, bus2.ERR, 0);
        chk({nm, ".oe"}, bus2.DATA_OE, 0);
        chk({nm, ".dout"}, bus2.DATA_OUT, 0);
        RST = 1'b1;
      end
    end
    repeat (2) @(negedge CLK);
    auto_txn(1'b1, 1'b0, AW'(3), '0, 4, {nm, ".readback"});
  endtask

  typedef struct {
    bit            r, w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            hold, er, ee, eo;
    logic [DW-1:0] erd;
  } vec_t;

  vec_t tbl [16];

  initial begin
    tbl[0]  = '{1'b0, 1'b1, 26'd5,        32'h1234_5678, 4,  3, -1, -1, 32'h0};
    tbl[1]  = '{1'b1, 1'b0, 26'd5,        32'h0,         6,  3, -1,  3, 32'h1234_5678};
    tbl[2]  = '{1'b0, 1'b1, 26'd10,       32'hDEAD_BEEF, 4,  3, -1, -1, 32'h0};
    tbl[3]  = '{1'b1, 1'b0, 26'd10,       32'h0,         4,  3, -1,  3, 32'hDEAD_BEEF};
    tbl[4]  = '{1'b0, 1'b1, 26'd0,        32'hA5A5_A5A5, 4,  3, -1, -1, 32'h0};
    tbl[5]  = '{1'b1, 1'b1, 26'd0,        32'hFFFF_FFFF, 3, -1,  1, -1, 32'h0};
    tbl[6]  = '{1'b1, 1'b0, 26'd0,        32'h0,         4,  3, -1,  3, 32'hA5A5_A5A5};
    tbl[7]  = '{1'b0, 1'b1, 26'h400,      32'h0000_0001, 4,  3,  3, -1, 32'h0};
    tbl[8]  = '{1'b1, 1'b0, 26'd0,        32'h0,         4,  3, -1,  3, 32'hA5A5_A5A5};
    tbl[9]  = '{1'b1, 1'b0, 26'h3FF_FFFF, 32'h0,         4,  3,  3,  3, 32'h0};
    tbl[10] = '{1'b0, 1'b1, 26'd3,        32'h0000_0033, 4,  3, -1, -1, 32'h0};
    tbl[11] = '{1'b0, 1'b1, 26'd3,        32'h0000_0007, 1, -1, -1, -1, 32'h0};
    tbl[12] = '{1'b0, 1'b1, 26'd3,        32'h0000_0007, 2, -1, -1, -1, 32'h0};
    tbl[13] = '{1'b1, 1'b0, 26'd3,        32'h0,         4,  3, -1,  3, 32'h0000_0033};
    tbl[14] = '{1'b0, 1'b1, 26'd3,        32'h0000_0007, 3,  3, -1, -1, 32'h0};
    tbl[15] = '{1'b1, 1'b0, 26'd3,        32'h0,         4,  3, -1,  3, 32'h0000_0007};

    rdc = '{0, 0}; wrc = '{0, 0};
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst.ready2", bus2.READY, 0);
    chk("rst.err2", bus2.ERR, 0);
    chk("rst.oe2", bus2.DATA_OE, 0);
    chk("rst.dout2", bus2.DATA_OUT, 0);
    chk("rst.ready0", bus0.READY, 0);
    chk("rst.dout0", bus0.DATA_OUT, 0);
`ifdef MEM_RESPONDER_STATS_EN
    chk("rst.rdcnt0", rdcnt0, 0);
    chk("rst.wrcnt0", wrcnt0, 0);
`endif
    RST = 1'b1;

    sel = 1'b0;
    for (int i = 0; i < 16; i++)
      do_txn(tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].hold,
             tbl[i].er, tbl[i].ee, tbl[i].eo, tbl[i].erd, $sformatf("vec%0d", i));

    rst_mid(0, "rst_wait");
    rst_mid(2, "rst_done");
    rdc = '{0, 0}; wrc = '{0, 0};

    // zero-wait responder: completion one cycle after capture
    sel = 1'b1;
    do_txn(1'b0, 1'b1, 26'd1, 32'h0000_0011, 2, 1, -1, -1, 32'h0, "w0.wr1");
    do_txn(1'b0, 1'b1, 26'd2, 32'h0000_0022, 1, 1, -1, -1, 32'h0, "w0.wr2");
    do_txn(1'b1, 1'b0, 26'd1, 32'h0,         2, 1, -1,  1, 32'h0000_0011, "w0.rd1");
    do_txn(1'b1, 1'b0, 26'd2, 32'h0,         3, 1, -1,  1, 32'h0000_0022, "w0.rd2");
    do_txn(1'b1, 1'b0, 26'd1, 32'h0,         2, 1, -1,  1, 32'h0000_0011, "w0.rd3");
    do_txn(1'b1, 1'b1, 26'd1, 32'h0000_00FF, 2, -1, 1, -1, 32'h0, "w0.both");
    do_txn(1'b1, 1'b0, 26'h800, 32'h0,       2, 1,  1,  1, 32'h0, "w0.oor");
`ifdef MEM_RESPONDER_STATS_EN
    chk("w0.rd_cnt", rdcnt0, 3);
    chk("w0.wr_cnt", wrcnt0, 2);
`endif

    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      for (int k = 0; k < 32; k++)
        auto_txn(1'b0, 1'b1, AW'(k), $urandom, wcyc(s) + 2, $sformatf("fill%0d_%0d", s, k));
    end

    for (int i = 0; i < 200; i++) begin
      int            kind, hold, W;
      bit            r, w;
      logic [AW-1:0] a;
      sel  = 1'($urandom_range(0, 1));
      W    = wcyc(int'(sel));
      kind = $urandom_range(0, 9);
      r    = (kind < 4) || (kind == 8);
      w    = (kind >= 4 && kind < 8) || (kind == 8);
      if (kind == 9) begin
        r = 1'($urandom_range(0, 1)); w = !r;
        hold = (W > 0) ? $urandom_range(1, W) : $urandom_range(1, 3);
      end else if (kind == 8) hold = $urandom_range(1, 3);
      else hold = W + 2 + $urandom_range(0, 2);
      if ($urandom_range(0, 99) < 15) a = AW'(1024 + $urandom_range(0, (1 << AW) - 1025));
      else a = AW'($urandom_range(0, 31));
      auto_txn(r, w, a, $urandom, hold, $sformatf("rnd%0d", i));
    end

`ifdef MEM_RESPONDER_STATS_EN
    chk("end.rdcnt2", rdcnt2, rdc[0]);
    chk("end.wrcnt2", wrcnt2, wrc[0]);
    chk("end.rdcnt0", rdcnt0, rdc[1]);
    chk("end.wrcnt0", wrcnt0, wrc[1]);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
